map_table: RTL and testbench

MAP_TABLE -- requirements
Module: map_table

---
 rtl/map_table_pkg.sv | 35 +++
 rtl/map_table_if.sv | 40 ++++
 rtl/map_table_arch.sv | 39 +++
 rtl/map_table.sv | 116 +++++++++++
 tb/tb_map_table.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/map_table_pkg.sv
// Shared definitions for the rename map table.
// Holds the slot count, tag widths, architectural register count, the hard-wired
// zero register/preg, the speculative entry type and a CDB tag-match helper.
package map_table_pkg;

  localparam int SCALAR_WIDTH   = 2;
  localparam int PREG_IDX_WIDTH = 6;
  localparam int NUM_ARCH_REGS  = 32;
  localparam int ARCH_IDX_WIDTH = $clog2(NUM_ARCH_REGS);

  typedef logic [ARCH_IDX_WIDTH-1:0] arch_idx_t;
  typedef logic [PREG_IDX_WIDTH-1:0] preg_idx_t;

  localparam arch_idx_t ZERO_REG  = '0;
  localparam preg_idx_t ZERO_PREG = '0;

  // One speculative map entry: current physical tag and its result-ready bit.
  typedef struct packed {
    preg_idx_t preg;
    logic      ready;
  } MT_ENTRY;

  // True when any valid CDB broadcast carries the given tag.
  function automatic logic cdb_hit(
    input preg_idx_t                    tag,
    input logic      [SCALAR_WIDTH-1:0] valid,
    input preg_idx_t [SCALAR_WIDTH-1:0] tags
  );
    cdb_hit = 1'b0;
    for (int unsigned k = 0; k < SCALAR_WIDTH; k++) begin
      if (valid[k] && (tags[k] == tag)) cdb_hit = 1'b1;
    end
  endfunction

endpackage

// File: rtl/map_table_if.sv
// Map-table bus: dispatch/rename, retire, CDB and rollback inputs plus the
// renamed-source and previous-mapping outputs.
//   master : the pipeline side (decoder, free list, ROB, CDB) driving requests
//   slave  : the map table consuming requests and returning renamed tags
interface map_table_if;
  import map_table_pkg::*;

  logic                                rollback_en;
  logic      [SCALAR_WIDTH-1:0]        dispatch_en;
  arch_idx_t [SCALAR_WIDTH-1:0]        dec_dest_idx;
  arch_idx_t [SCALAR_WIDTH-1:0]        dec_src1_idx;
  arch_idx_t [SCALAR_WIDTH-1:0]        dec_src2_idx;
  preg_idx_t [SCALAR_WIDTH-1:0]        FL_T_idx;
  logic      [SCALAR_WIDTH-1:0]        retire_en;
  arch_idx_t [SCALAR_WIDTH-1:0]        ROB_retire_dest_idx;
  preg_idx_t [SCALAR_WIDTH-1:0]        ROB_retire_T_idx;
  logic      [SCALAR_WIDTH-1:0]        CDB_valid;
  preg_idx_t [SCALAR_WIDTH-1:0]        CDB_T_idx;

  preg_idx_t [SCALAR_WIDTH-1:0]        MT_T1_idx;
  preg_idx_t [SCALAR_WIDTH-1:0]        MT_T2_idx;
  logic      [SCALAR_WIDTH-1:0]        MT_T1_ready;
  logic      [SCALAR_WIDTH-1:0]        MT_T2_ready;
  preg_idx_t [SCALAR_WIDTH-1:0]        MT_Told_idx;

  modport master (
    output rollback_en, dispatch_en, dec_dest_idx, dec_src1_idx, dec_src2_idx,
           FL_T_idx, retire_en, ROB_retire_dest_idx, ROB_retire_T_idx,
           CDB_valid, CDB_T_idx,
    input  MT_T1_idx, MT_T2_idx, MT_T1_ready, MT_T2_ready, MT_Told_idx
  );

  modport slave (
    input  rollback_en, dispatch_en, dec_dest_idx, dec_src1_idx, dec_src2_idx,
           FL_T_idx, retire_en, ROB_retire_dest_idx, ROB_retire_T_idx,
           CDB_valid, CDB_T_idx,
    output MT_T1_idx, MT_T2_idx, MT_T1_ready, MT_T2_ready, MT_Told_idx
  );

endinterface

// File: rtl/map_table_arch.sv
// Architectural (committed) map table.
//   clock, reset        : clock and asynchronous active-high reset (identity map)
//   retire_en           : per-slot retire valid
//   retire_dest_idx     : per-slot retiring architectural destination
//   retire_T_idx        : per-slot retiring physical tag
//   rollback_table      : full table including this cycle's retire writes, used
//                         to restore the speculative table on a mispredict
module arch_map_table
  import map_table_pkg::*;
(
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic      [SCALAR_WIDTH-1:0]         retire_en,
  input  arch_idx_t [SCALAR_WIDTH-1:0]         retire_dest_idx,
  input  preg_idx_t [SCALAR_WIDTH-1:0]         retire_T_idx,
  output preg_idx_t [NUM_ARCH_REGS-1:0]        rollback_table
);

  preg_idx_t [NUM_ARCH_REGS-1:0] arch_table;

  // Higher slot is applied last so it wins a same-destination collision.
  always_comb begin
    rollback_table = arch_table;
    for (int unsigned s = 0; s < SCALAR_WIDTH; s++) begin
      if (retire_en[s] && (retire_dest_idx[s] != ZERO_REG))
        rollback_table[retire_dest_idx[s]] = retire_T_idx[s];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ARCH_REGS; i++)
        arch_table[i] <= PREG_IDX_WIDTH'(i);
    end else begin
      arch_table <= rollback_table;
    end
  end

endmodule

// File: rtl/map_table.sv
// Register-rename map table for a 2-wide pipeline.
//   clock, reset : clock and asynchronous active-high reset (identity mapping,
//                  all ready)
//   mt           : map_table_if slave -- dispatch/rename requests, retire, CDB
//                  broadcasts and rollback in; renamed source tags with ready
//                  bits and each slot's previous destination mapping out
// Outputs are combinational from the speculative table plus intra-bundle and
// CDB bypasses; table writes become visible the following cycle.
module map_table
  import map_table_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  map_table_if.slave mt
);

  MT_ENTRY                          spec_table [NUM_ARCH_REGS];
  MT_ENTRY                          spec_next  [NUM_ARCH_REGS];
  preg_idx_t [NUM_ARCH_REGS-1:0]    rollback_table;

  logic                             slot0_writes;
  arch_idx_t                        dest0;
  preg_idx_t                        fl0;
  logic      [SCALAR_WIDTH-1:0]     cdb_valid;
  preg_idx_t [SCALAR_WIDTH-1:0]     cdb_tags;

  assign dest0        = mt.dec_dest_idx[0];
  assign fl0          = mt.FL_T_idx[0];
  assign slot0_writes = mt.dispatch_en[0] && (dest0 != ZERO_REG);
  assign cdb_valid    = mt.CDB_valid;
  assign cdb_tags     = mt.CDB_T_idx;

  arch_map_table u_arch (
    .clock           (clock),
    .reset           (reset),
    .retire_en       (mt.retire_en),
    .retire_dest_idx (mt.ROB_retire_dest_idx),
    .retire_T_idx    (mt.ROB_retire_T_idx),
    .rollback_table  (rollback_table)
  );

  // A slot-1 source renamed by slot 0 in the same bundle takes slot 0's new
  // tag and stays not-ready; a CDB hit must not mark that fresh tag ready.
  function automatic MT_ENTRY read_src(input arch_idx_t src, input logic from_slot1);
    MT_ENTRY e;
    logic    bypassed;
    e        = spec_table[src];
    bypassed = 1'b0;
    if (src == ZERO_REG) begin
      e = '{preg: ZERO_PREG, ready: 1'b1};
    end else if (from_slot1 && slot0_writes && (src == dest0)) begin
      e        = '{preg: fl0, ready: 1'b0};
      bypassed = 1'b1;
    end
    if (!bypassed && (e.preg != ZERO_PREG) && cdb_hit(e.preg, cdb_valid, cdb_tags))
      e.ready = 1'b1;
    return e;
  endfunction

  always_comb begin
    MT_ENTRY e1;
    MT_ENTRY e2;
    arch_idx_t dest;
    mt.MT_T1_idx   = '0;
    mt.MT_T2_idx   = '0;
    mt.MT_T1_ready = '0;
    mt.MT_T2_ready = '0;
    mt.MT_Told_idx = '0;
    for (int unsigned s = 0; s < SCALAR_WIDTH; s++) begin
      e1 = read_src(mt.dec_src1_idx[s], s == 1);
      e2 = read_src(mt.dec_src2_idx[s], s == 1);
      mt.MT_T1_idx[s]   = e1.preg;
      mt.MT_T1_ready[s] = e1.ready;
      mt.MT_T2_idx[s]   = e2.preg;
      mt.MT_T2_ready[s] = e2.ready;
      dest = mt.dec_dest_idx[s];
      if (mt.dispatch_en[s] && (dest != ZERO_REG)) begin
        if ((s == 1) && slot0_writes && (dest == dest0))
          mt.MT_Told_idx[s] = fl0;
        else
          mt.MT_Told_idx[s] = spec_table[dest].preg;
      end
    end
  end

  // Rollback overrides everything; otherwise CDB readiness is applied first so
  // that a dispatch write to the same entry overrides it, slot 1 last.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ARCH_REGS; i++)
      spec_next[i] = spec_table[i];
    if (mt.rollback_en) begin
      for (int unsigned i = 0; i < NUM_ARCH_REGS; i++)
        spec_next[i] = '{preg: rollback_table[i], ready: 1'b1};
    end else begin
      for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
        if (cdb_hit(spec_table[i].preg, cdb_valid, cdb_tags))
          spec_next[i].ready = 1'b1;
      end
      for (int unsigned s = 0; s < SCALAR_WIDTH; s++) begin
        if (mt.dispatch_en[s] && (mt.dec_dest_idx[s] != ZERO_REG))
          spec_next[mt.dec_dest_idx[s]] = '{preg: mt.FL_T_idx[s], ready: 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ARCH_REGS; i++)
        spec_table[i] <= '{preg: PREG_IDX_WIDTH'(i), ready: 1'b1};
    end else begin
      for (int unsigned i = 0; i < NUM_ARCH_REGS; i++)
        spec_table[i] <= spec_next[i];
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Self-checking bench for map_table: directed scenarios followed by random
// traffic, compared against an array-based reference model of the rename rules.
module tb_map_table;
  import map_table_pkg::*;

  logic clock;
  logic reset;

  map_table_if mif();

  map_table dut (
    .clock (clock),
    .reset (reset),
    .mt    (mif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  int m_preg [NUM_ARCH_REGS];
  bit m_rdy  [NUM_ARCH_REGS];
  int m_arch [NUM_ARCH_REGS];

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ARCH_REGS; i++) begin
      m_preg[i] = i;
      m_rdy[i]  = 1'b1;
      m_arch[i] = i;
    end
  endtask

  function automatic bit cdb_match(input int tag);
    for (int k = 0; k < SCALAR_WIDTH; k++)
      if (mif.CDB_valid[k] && int'(mif.CDB_T_idx[k]) == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit slot0_renames(input int src);
    return mif.dispatch_en[0] && mif.dec_dest_idx[0] != 0 && int'(mif.dec_dest_idx[0]) == src;
  endfunction

  task automatic exp_src(input int s, input int src, output int tag, output int rdy);
    if (src == 0) begin
      tag = 0; rdy = 1;
    end else if (s == 1 && slot0_renames(src)) begin
      tag = int'(mif.FL_T_idx[0]); rdy = 0;
    end else begin
      tag = m_preg[src];
      rdy = (m_rdy[src] || (tag != 0 && cdb_match(tag))) ? 1 : 0;
    end
  endtask

  function automatic int exp_told(input int s);
    int dest;
    dest = int'(mif.dec_dest_idx[s]);
    if (!mif.dispatch_en[s] || dest == 0) return 0;
    if (s == 1 && slot0_renames(dest)) return int'(mif.FL_T_idx[0]);
    return m_preg[dest];
  endfunction

  task automatic check_outputs(input string ctx);
    int t, r;
    for (int s = 0; s < SCALAR_WIDTH; s++) begin
      exp_src(s, int'(mif.dec_src1_idx[s]), t, r);
      check($sformatf("%s T1[%0d]", ctx, s), 32'(mif.MT_T1_idx[s]), t);
      check($sformatf("%s T1rdy[%0d]", ctx, s), 32'(mif.MT_T1_ready[s]), r);
      exp_src(s, int'(mif.dec_src2_idx[s]), t, r);
      check($sformatf("%s T2[%0d]", ctx, s), 32'(mif.MT_T2_idx[s]), t);
      check($sformatf("%s T2rdy[%0d]", ctx, s), 32'(mif.MT_T2_ready[s]), r);
      check($sformatf("%s Told[%0d]", ctx, s), 32'(mif.MT_Told_idx[s]), exp_told(s));
    end
  endtask

  // Clock-edge update of the model from the inputs held across the edge.
  task automatic model_clock();
    int  new_arch [NUM_ARCH_REGS];
    bit  hit [NUM_ARCH_REGS];
    for (int i = 0; i < NUM_ARCH_REGS; i++) new_arch[i] = m_arch[i];
    for (int s = 0; s < SCALAR_WIDTH; s++)
      if (mif.retire_en[s] && mif.ROB_retire_dest_idx[s] != 0)
        new_arch[int'(mif.ROB_retire_dest_idx[s])] = int'(mif.ROB_retire_T_idx[s]);
    if (mif.rollback_en) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        m_preg[i] = new_arch[i];
        m_rdy[i]  = 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) hit[i] = cdb_match(m_preg[i]);
      for (int i = 0; i < NUM_ARCH_REGS; i++) if (hit[i]) m_rdy[i] = 1'b1;
      for (int s = 0; s < SCALAR_WIDTH; s++)
        if (mif.dispatch_en[s] && mif.dec_dest_idx[s] != 0) begin
          m_preg[int'(mif.dec_dest_idx[s])] = int'(mif.FL_T_idx[s]);
          m_rdy[int'(mif.dec_dest_idx[s])]  = 1'b0;
        end
    end
    for (int i = 0; i < NUM_ARCH_REGS; i++) m_arch[i] = new_arch[i];
  endtask

  task automatic step(input string ctx);
    #1 check_outputs(ctx);
    @(posedge clock);
    model_clock();
    @(negedge clock);
  endtask

  task automatic idle();
    mif.rollback_en         = 1'b0;
    mif.dispatch_en         = '0;
    mif.dec_dest_idx        = '0;
    mif.dec_src1_idx        = '0;
    mif.dec_src2_idx        = '0;
    mif.FL_T_idx            = '0;
    mif.retire_en           = '0;
    mif.ROB_retire_dest_idx = '0;
    mif.ROB_retire_T_idx    = '0;
    mif.CDB_valid           = '0;
    mif.CDB_T_idx           = '0;
  endtask

  task automatic set_src(input int s, input int a, input int b);
    mif.dec_src1_idx[s] = ARCH_IDX_WIDTH'(a);
    mif.dec_src2_idx[s] = ARCH_IDX_WIDTH'(b);
  endtask

  task automatic set_disp(input int s, input int dest, input int fl);
    mif.dispatch_en[s]  = 1'b1;
    mif.dec_dest_idx[s] = ARCH_IDX_WIDTH'(dest);
    mif.FL_T_idx[s]     = PREG_IDX_WIDTH'(fl);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    step("reset_idle");

    // Identity after reset.
    idle(); set_src(0, 5, 7);
    #1;
    check("r031 T1", 32'(mif.MT_T1_idx[0]), 5);
    check("r031 T2", 32'(mif.MT_T2_idx[0]), 7);
    check("r031 T1rdy", 32'(mif.MT_T1_ready[0]), 1);
    check("r031 T2rdy", 32'(mif.MT_T2_ready[0]), 1);
    step("r031");

    // Intra-bundle rename of dest 3.
    idle(); set_disp(0, 3, 40); set_disp(1, 3, 41); set_src(1, 3, 0);
    #1;
    check("r032 T1[1]", 32'(mif.MT_T1_idx[1]), 40);
    check("r032 T1rdy[1]", 32'(mif.MT_T1_ready[1]), 0);
    check("r032 Told[0]", 32'(mif.MT_Told_idx[0]), 3);
    check("r032 Told[1]", 32'(mif.MT_Told_idx[1]), 40);
    step("r032");
    idle(); set_src(0, 3, 0);
    #1;
    check("r032 next T1", 32'(mif.MT_T1_idx[0]), 41);
    check("r032 next rdy", 32'(mif.MT_T1_ready[0]), 0);

    // CDB wakes up tag 41 in the same cycle, then it sticks.
    mif.CDB_valid[0] = 1'b1; mif.CDB_T_idx[0] = 6'd41;
    #1;
    check("r033 bypass rdy", 32'(mif.MT_T1_ready[0]), 1);
    step("r033");
    idle(); set_src(0, 3, 0);
    #1;
    check("r033 next T1", 32'(mif.MT_T1_idx[0]), 41);
    check("r033 next rdy", 32'(mif.MT_T1_ready[0]), 1);
    step("r033b");

    // Rollback with a same-cycle retire of dest 4 / tag 50.
    idle(); set_disp(0, 4, 50); step("r034a");
    idle(); mif.rollback_en = 1'b1; mif.retire_en[0] = 1'b1;
    mif.ROB_retire_dest_idx[0] = 5'd4; mif.ROB_retire_T_idx[0] = 6'd50;
    step("r034b");
    idle(); set_src(0, 4, 3);
    #1;
    check("r034 T1", 32'(mif.MT_T1_idx[0]), 50);
    check("r034 T1rdy", 32'(mif.MT_T1_ready[0]), 1);
    check("r034 T2", 32'(mif.MT_T2_idx[0]), 3);
    check("r034 T2rdy", 32'(mif.MT_T2_ready[0]), 1);
    step("r034c");

    // Zero destination on both slots.
    idle(); set_disp(0, 0, 12); set_disp(1, 0, 13); set_src(0, 0, 0);
    #1;
    check("r035 Told[0]", 32'(mif.MT_Told_idx[0]), 0);
    check("r035 Told[1]", 32'(mif.MT_Told_idx[1]), 0);
    step("r035a");
    idle();
    #1;
    check("r035 T1", 32'(mif.MT_T1_idx[0]), 0);
    check("r035 T1rdy", 32'(mif.MT_T1_ready[0]), 1);
    step("r035b");

    // Slot 1 dispatching alone.
    idle(); set_disp(1, 6, 22); step("slot1_only");
    idle(); set_src(0, 6, 6); step("slot1_only_read");

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int s = 0; s < SCALAR_WIDTH; s++) begin
        mif.dispatch_en[s]         = 1'($urandom_range(0, 1));
        mif.dec_dest_idx[s]        = ARCH_IDX_WIDTH'($urandom_range(0, 31));
        mif.dec_src1_idx[s]        = ARCH_IDX_WIDTH'($urandom_range(0, 31));
        mif.dec_src2_idx[s]        = ARCH_IDX_WIDTH'($urandom_range(0, 31));
        mif.FL_T_idx[s]            = PREG_IDX_WIDTH'($urandom_range(1, 63));
        mif.retire_en[s]           = 1'($urandom_range(0, 1));
        mif.ROB_retire_dest_idx[s] = ARCH_IDX_WIDTH'($urandom_range(0, 31));
        mif.ROB_retire_T_idx[s]    = PREG_IDX_WIDTH'($urandom_range(1, 63));
        mif.CDB_valid[s]           = 1'($urandom_range(0, 1));
        mif.CDB_T_idx[s]           = PREG_IDX_WIDTH'(m_preg[$urandom_range(0, 31)]);
      end
      if ($urandom_range(0, 3) == 0) mif.dec_src1_idx[1] = mif.dec_dest_idx[0];
      if ($urandom_range(0, 3) == 0) mif.dec_dest_idx[1] = mif.dec_dest_idx[0];
      mif.rollback_en = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    // Reset between edges after writes returns the identity map at once.
    idle(); set_disp(0, 9, 33); set_disp(1, 10, 34); step("pre_reset");
    idle();
    #2 reset = 1'b1;
    model_reset();
    for (int i = 0; i < NUM_ARCH_REGS; i++) begin
      set_src(0, i, i);
      set_src(1, i, i);
      #1;
      check($sformatf("r036 T1[0] reg%0d", i), 32'(mif.MT_T1_idx[0]), i);
      check($sformatf("r036 T2[1] reg%0d", i), 32'(mif.MT_T2_idx[1]), i);
      check($sformatf("r036 rdy reg%0d", i), 32'(mif.MT_T1_ready[0] & mif.MT_T2_ready[1]), 1);
    end
    @(negedge clock);
    reset = 1'b0;
    idle();
    @(negedge clock);
    step("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
